// File: rtl/riscv_hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: clear codes and
// the divide sequencer state encoding.
package riscv_hazard_pkg;

  localparam logic [1:0] CLR_NORM  = 2'b00;
  localparam logic [1:0] CLR_STALL = 2'b01;
  localparam logic [1:0] CLR_FLUSH = 2'b11;

  localparam int DIV_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } div_state_t;

endpackage

// File: rtl/hazard_div_timer.sv
// Divide sequencer: tracks how long a multi-cycle divide has held EX and
// flags the final (release) cycle.
module hazard_div_timer
  import riscv_hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic last
);

  localparam bit MULTI = (DIV_CYCLES >= 2);
  localparam int LOAD_INT = MULTI ? (DIV_CYCLES - 2) : 0;
  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(LOAD_INT);

  div_state_t state, state_n;
  logic [DIV_CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The first stall cycle is spent in IDLE, so DIV only needs DIV_CYCLES-2
  // further stall cycles before its release cycle at cnt==0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start && MULTI) begin
          state_n = DIV;
          cnt_n   = CNT_LOAD;
        end
      end
      DIV: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == DIV);
  assign last = busy && (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: divide stalls, branch flushes and load-use
// stalls. Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl
  import riscv_hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_div_start,
  output logic                  pc_write,
  output logic [1:0]            if_id_clear,
  output logic [1:0]            id_ex_clear,
  output logic [1:0]            ex_mem_clear,
  output logic [1:0]            mem_wb_clear,
  output logic                  busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_events
`endif
);

  localparam bit MULTI = (DIV_CYCLES >= 2);

  logic div_last;
  logic div_stall;
  logic load_use;
  logic branch_flush;

  hazard_div_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_timer (
    .clk  (clk),
    .rst  (rst),
    .start(ex_div_start),
    .busy (busy),
    .last (div_last)
  );

  // In the release cycle of a divide ex_div_start is ignored so the
  // branch and load-use rules get their normal chance.
  assign div_stall = busy ? !div_last : (ex_div_start && MULTI);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign branch_flush = !rst && !div_stall && ex_branch_taken;

  always_comb begin
    pc_write     = 1'b1;
    if_id_clear  = CLR_NORM;
    id_ex_clear  = CLR_NORM;
    ex_mem_clear = CLR_NORM;
    mem_wb_clear = CLR_NORM;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_clear  = CLR_FLUSH;
      id_ex_clear  = CLR_FLUSH;
      ex_mem_clear = CLR_FLUSH;
      mem_wb_clear = CLR_FLUSH;
    end else if (div_stall) begin
      pc_write     = 1'b0;
      if_id_clear  = CLR_STALL;
      id_ex_clear  = CLR_STALL;
      ex_mem_clear = CLR_FLUSH;
    end else if (ex_branch_taken) begin
      if_id_clear  = CLR_FLUSH;
      id_ex_clear  = CLR_FLUSH;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_clear  = CLR_STALL;
      id_ex_clear  = CLR_FLUSH;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (!pc_write)    perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (branch_flush) perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = branch_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl, driving three instances in parallel
// (DIV_CYCLES = 4, 1 and 32) from one shared set of inputs.
module tb_hazard_ctrl;

  typedef struct {
    string      tag;
    logic [9:0] e4;
    logic [9:0] e1;
    logic [9:0] e32;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_div_start = 1'b0;

  wire [9:0] obs4, obs1, obs32;
`ifdef HAZARD_PERF_EN
  wire [31:0] stall4, flush4, stall1, flush1, stall32, flush32;
`endif

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_div_start(ex_div_start), .pc_write(obs4[9]), .if_id_clear(obs4[8:7]),
    .id_ex_clear(obs4[6:5]), .ex_mem_clear(obs4[4:3]), .mem_wb_clear(obs4[2:1]),
    .busy(obs4[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(stall4), .perf_flush_events(flush4)
`endif
  );

  hazard_ctrl #(.DIV_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_div_start(ex_div_start), .pc_write(obs1[9]), .if_id_clear(obs1[8:7]),
    .id_ex_clear(obs1[6:5]), .ex_mem_clear(obs1[4:3]), .mem_wb_clear(obs1[2:1]),
    .busy(obs1[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(stall1), .perf_flush_events(flush1)
`endif
  );

  hazard_ctrl #(.DIV_CYCLES(32)) dut32 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_div_start(ex_div_start), .pc_write(obs32[9]), .if_id_clear(obs32[8:7]),
    .id_ex_clear(obs32[6:5]), .ex_mem_clear(obs32[4:3]), .mem_wb_clear(obs32[2:1]),
    .busy(obs32[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(stall32), .perf_flush_events(flush32)
`endif
  );

  // Expected output vector: {pc_write, if_id, id_ex, ex_mem, mem_wb, busy}
  function automatic logic [9:0] pat(input logic pc, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] c,
                                     input logic [1:0] d, input logic bsy);
    return {pc, a, b, c, d, bsy};
  endfunction

  function automatic logic [9:0] dflt(input logic bsy);
    return pat(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, bsy);
  endfunction
  function automatic logic [9:0] divs(input logic bsy);
    return pat(1'b0, 2'b01, 2'b01, 2'b11, 2'b00, bsy);
  endfunction
  function automatic logic [9:0] brf(input logic bsy);
    return pat(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, bsy);
  endfunction
  function automatic logic [9:0] lus(input logic bsy);
    return pat(1'b0, 2'b01, 2'b11, 2'b00, 2'b00, bsy);
  endfunction
  function automatic logic [9:0] rstp();
    return pat(1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 1'b0);
  endfunction

  task automatic compareVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compareVal("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    compareVal({e.tag, "/div4"},  {22'd0, obs4},  {22'd0, e.e4});
    compareVal({e.tag, "/div1"},  {22'd0, obs1},  {22'd0, e.e1});
    compareVal({e.tag, "/div32"}, {22'd0, obs32}, {22'd0, e.e32});
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic dv,
                               input logic br, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [9:0] e4, input logic [9:0] e1,
                               input logic [9:0] e32);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_div_start = dv; ex_branch_taken = br; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    e.tag = tag; e.e4 = e4; e.e1 = e1; e.e32 = e32;
    sb.push_back(e);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] hazard_ctrl bench start");
    applyStimulus("reset",      1,0,0,0, 0, 0,0, 0,0, rstp(), rstp(), rstp());
    applyStimulus("idle",       0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), dflt(0));
    applyStimulus("lu_rs2",     0,0,0,1, 5, 0,0, 5,1, lus(0), lus(0), lus(0));
    applyStimulus("lu_release", 0,0,0,0, 5, 0,0, 5,1, dflt(0), dflt(0), dflt(0));
    applyStimulus("lu_rd0",     0,0,0,1, 0, 0,0, 0,1, dflt(0), dflt(0), dflt(0));
    applyStimulus("lu_rs1",     0,0,0,1, 7, 7,1, 0,0, lus(0), lus(0), lus(0));
    applyStimulus("lu_unused",  0,0,0,1, 7, 7,0, 7,0, dflt(0), dflt(0), dflt(0));
    applyStimulus("branch",     0,0,1,0, 0, 0,0, 0,0, brf(0), brf(0), brf(0));
    applyStimulus("br_release", 0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), dflt(0));

    applyStimulus("div_c1",     0,1,0,0, 0, 0,0, 0,0, divs(0), dflt(0), divs(0));
    applyStimulus("div_c2",     0,1,0,0, 0, 0,0, 0,0, divs(1), dflt(0), divs(1));
    applyStimulus("div_c3",     0,1,0,0, 0, 0,0, 0,0, divs(1), dflt(0), divs(1));
    applyStimulus("div_c4",     0,1,0,0, 0, 0,0, 0,0, dflt(1), dflt(0), divs(1));
    applyStimulus("div_rst",    1,0,0,0, 0, 0,0, 0,0, rstp(), rstp(), rstp());

    // Divide beats load-use in IDLE; load-use wins the release cycle
    applyStimulus("sim_c1",     0,1,0,1, 5, 0,0, 5,1, divs(0), lus(0), divs(0));
    applyStimulus("sim_c2",     0,1,0,1, 5, 0,0, 5,1, divs(1), lus(0), divs(1));
    applyStimulus("sim_c3",     0,1,0,1, 5, 0,0, 5,1, divs(1), lus(0), divs(1));
    applyStimulus("sim_c4",     0,1,0,1, 5, 0,0, 5,1, lus(1), lus(0), divs(1));
    applyStimulus("sim_c5",     0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), divs(1));
    applyStimulus("sim_rst",    1,0,0,0, 0, 0,0, 0,0, rstp(), rstp(), rstp());

    applyStimulus("mid_c1",     0,1,0,0, 0, 0,0, 0,0, divs(0), dflt(0), divs(0));
    applyStimulus("mid_c2",     0,1,0,0, 0, 0,0, 0,0, divs(1), dflt(0), divs(1));
    applyStimulus("mid_rst",    1,1,0,0, 0, 0,0, 0,0, rstp(), rstp(), rstp());
    applyStimulus("mid_after",  0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), dflt(0));

    // Branch ignored mid-divide, wins over load-use in the release cycle
    applyStimulus("bdiv_c1",    0,1,1,0, 0, 0,0, 0,0, divs(0), brf(0), divs(0));
    applyStimulus("bdiv_c2",    0,1,1,0, 0, 0,0, 0,0, divs(1), brf(0), divs(1));
    applyStimulus("bdiv_c3",    0,1,0,0, 0, 0,0, 0,0, divs(1), dflt(0), divs(1));
    applyStimulus("bdiv_c4",    0,1,1,1, 9, 9,1, 0,0, brf(1), brf(0), divs(1));
    applyStimulus("bdiv_rst",   1,0,0,0, 0, 0,0, 0,0, rstp(), rstp(), rstp());
    applyStimulus("bdiv_after", 0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), dflt(0));

`ifdef HAZARD_PERF_EN
    applyStimulus("perf_rst",   1,0,0,0, 0, 0,0, 0,0, rstp(), rstp(), rstp());
    applyStimulus("perf_d1",    0,1,0,0, 0, 0,0, 0,0, divs(0), dflt(0), divs(0));
    applyStimulus("perf_d2",    0,1,0,0, 0, 0,0, 0,0, divs(1), dflt(0), divs(1));
    applyStimulus("perf_d3",    0,1,0,0, 0, 0,0, 0,0, divs(1), dflt(0), divs(1));
    applyStimulus("perf_d4",    0,1,0,0, 0, 0,0, 0,0, dflt(1), dflt(0), divs(1));
    applyStimulus("perf_lu",    0,0,0,1, 3, 3,1, 0,0, lus(0), lus(0), divs(1));
    applyStimulus("perf_br1",   0,0,1,0, 0, 0,0, 0,0, brf(0), brf(0), divs(1));
    applyStimulus("perf_gap",   0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), divs(1));
    applyStimulus("perf_br2",   0,0,1,0, 0, 0,0, 0,0, brf(0), brf(0), divs(1));
    applyStimulus("perf_end",   0,0,0,0, 0, 0,0, 0,0, dflt(0), dflt(0), divs(1));
    compareVal("perf_stall_div4", stall4, 32'd4);
    compareVal("perf_flush_div4", flush4, 32'd2);
    compareVal("perf_stall_div1", stall1, 32'd1);
    compareVal("perf_flush_div1", flush1, 32'd2);
`endif

    if (sb.size() != 0) compareVal("scoreboard_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
